// File: rtl/boot_sequencer.sv
// Multi-core boot sequencer: holds cores in reset, pulses per-channel starts,
// then watches for completion or a run-time watchdog expiry.
module boot_sequencer #(
    parameter int NCH          = 4,
    parameter int RST_HOLD     = 2,
    parameter int START_W      = 1,
    parameter int TIMEOUT      = 50000,
    parameter int CNT_W        = 20,
    parameter int AUTO_RESTART = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_start,
    input  logic             abort,
    input  logic [NCH-1:0]   ch_enable,
    input  logic [NCH-1:0]   halt_in,
    output logic             cpu_rst,
    output logic [NCH-1:0]   cpu_start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] run_cycles
);

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int SW = (START_W > 1) ? $clog2(START_W) : 1;

    localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_HOLD - 1);
    localparam logic [SW-1:0]    START_LAST = SW'(START_W - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RUN_MAX    = {CNT_W{1'b1}};
    localparam logic             AUTO       = (AUTO_RESTART != 0) ? 1'b1 : 1'b0;

    logic [2:0]     state_r;
    logic [HW-1:0]  hold_cnt_r;
    logic [SW-1:0]  start_cnt_r;
    logic [NCH-1:0] mask_r;
    logic           all_halted_s;
    logic           at_limit_s;

    // Completion and watchdog conditions evaluated against the latched mask.
    always_comb begin
        all_halted_s = ((halt_in & mask_r) == mask_r);
        at_limit_s   = (run_cycles == RUN_LAST);
    end

    // Sequencer state machine; every output is driven from a flop here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_RESET;
            hold_cnt_r  <= {HW{1'b0}};
            start_cnt_r <= {SW{1'b0}};
            mask_r      <= {NCH{1'b0}};
            cpu_rst     <= 1'b1;
            cpu_start   <= {NCH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            run_cycles  <= {CNT_W{1'b0}};
        end else if (abort) begin
            state_r    <= S_RESET;
            hold_cnt_r <= {HW{1'b0}};
            cpu_rst    <= 1'b1;
            cpu_start  <= {NCH{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state_r)
                S_RESET: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r <= S_IDLE;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                S_IDLE: begin
                    if (ext_start && (ch_enable != {NCH{1'b0}})) begin
                        state_r     <= S_START;
                        mask_r      <= ch_enable;
                        start_cnt_r <= {SW{1'b0}};
                        cpu_start   <= ch_enable;
                        busy        <= 1'b1;
                    end
                end
                S_START: begin
                    if (start_cnt_r == START_LAST) begin
                        state_r    <= S_RUN;
                        cpu_start  <= {NCH{1'b0}};
                        run_cycles <= {CNT_W{1'b0}};
                    end else begin
                        start_cnt_r <= start_cnt_r + SW'(1);
                    end
                end
                S_RUN: begin
                    // Completion wins over the watchdog when both fire together.
                    if (all_halted_s) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else if (at_limit_s) begin
                        state_r <= S_DONE;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                    end else if (run_cycles != RUN_MAX) begin
                        run_cycles <= run_cycles + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (AUTO || ext_start) begin
                        state_r    <= S_RESET;
                        hold_cnt_r <= {HW{1'b0}};
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_RESET;
                    hold_cnt_r <= {HW{1'b0}};
                    cpu_rst    <= 1'b1;
                    cpu_start  <= {NCH{1'b0}};
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    timeout    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a vector table for the main boot flow plus
// hand-written sequences for watchdog, abort, mid-run reset and auto restart.
module tb_boot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ext_start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] ch_enable = 4'd0;
    logic [3:0] halt_in = 4'd0;

    logic       cpu_rst0, busy0, done0, timeout0;
    logic [3:0] cpu_start0;
    logic [7:0] run_cycles0;
    logic       cpu_rst1, busy1, done1, timeout1;
    logic [3:0] cpu_start1;
    logic [7:0] run_cycles1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    boot_sequencer #(.NCH(4), .RST_HOLD(3), .START_W(2), .TIMEOUT(10), .CNT_W(8), .AUTO_RESTART(0)) dut0 (
        .clk(clk), .rst(rst), .ext_start(ext_start), .abort(abort),
        .ch_enable(ch_enable), .halt_in(halt_in),
        .cpu_rst(cpu_rst0), .cpu_start(cpu_start0), .busy(busy0),
        .done(done0), .timeout(timeout0), .run_cycles(run_cycles0)
    );

    boot_sequencer #(.NCH(4), .RST_HOLD(3), .START_W(2), .TIMEOUT(10), .CNT_W(8), .AUTO_RESTART(1)) dut1 (
        .clk(clk), .rst(rst), .ext_start(ext_start), .abort(abort),
        .ch_enable(ch_enable), .halt_in(halt_in),
        .cpu_rst(cpu_rst1), .cpu_start(cpu_start1), .busy(busy1),
        .done(done1), .timeout(timeout1), .run_cycles(run_cycles1)
    );

    typedef struct {
        logic       rst;
        logic       ext_start;
        logic       abort;
        logic [3:0] ch_enable;
        logic [3:0] halt_in;
        logic       e_cpu_rst;
        logic [3:0] e_cpu_start;
        logic       e_busy;
        logic       e_done;
        logic       e_timeout;
        logic [7:0] e_rc;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic r, input logic [3:0] s, input logic b,
                        input logic d, input logic t);
        chk({tag, ".cpu_rst"}, {7'd0, cpu_rst0}, {7'd0, r});
        chk({tag, ".cpu_start"}, {4'd0, cpu_start0}, {4'd0, s});
        chk({tag, ".busy"}, {7'd0, busy0}, {7'd0, b});
        chk({tag, ".done"}, {7'd0, done0}, {7'd0, d});
        chk({tag, ".timeout"}, {7'd0, timeout0}, {7'd0, t});
    endtask

    // Accept a start with channel set ch and advance through the two start cycles into run.
    task automatic start_run(input logic [3:0] ch);
        ext_start = 1'b1;
        ch_enable = ch;
        tick();
        ext_start = 1'b0;
        tick();
        tick();
    endtask

    task automatic restart_to_idle();
        ext_start = 1'b1;
        tick();
        ext_start = 1'b0;
        tick();
        tick();
        tick();
        chk("restart.idle", {7'd0, cpu_rst0}, 8'd0);
    endtask

    initial begin
        //            rst   ext   abt   ch     halt  | crst  cstart busy  done  to    rc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd5};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'd5};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd5};

        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            rst       = vecs[i].rst;
            ext_start = vecs[i].ext_start;
            abort     = vecs[i].abort;
            ch_enable = vecs[i].ch_enable;
            halt_in   = vecs[i].halt_in;
            tick();
            chk0($sformatf("vec%0d", i), vecs[i].e_cpu_rst, vecs[i].e_cpu_start,
                 vecs[i].e_busy, vecs[i].e_done, vecs[i].e_timeout);
            chk($sformatf("vec%0d.run_cycles", i), run_cycles0, vecs[i].e_rc);
        end
        ext_start = 1'b0;
        halt_in   = 4'h0;

        // Watchdog: halt_in never completes.
        start_run(4'h3);
        for (int i = 0; i < 9; i++) tick();
        chk0("to.pre", 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("to.pre.rc", run_cycles0, 8'd9);
        tick();
        chk0("to.hit", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("to.hit.rc", run_cycles0, 8'd9);
        tick();
        chk0("to.hold", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("to.hold.rc", run_cycles0, 8'd9);
        restart_to_idle();
        chk("to.cleared", {7'd0, timeout0}, 8'd0);

        // Completion on the same cycle as the watchdog limit.
        start_run(4'h3);
        for (int i = 0; i < 9; i++) tick();
        halt_in = 4'h3;
        tick();
        halt_in = 4'h0;
        chk0("tie", 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("tie.rc", run_cycles0, 8'd9);
        restart_to_idle();

        // Abort during run.
        start_run(4'h8);
        tick();
        tick();
        chk("abort.pre.rc", run_cycles0, 8'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk0("abort.run", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("abort.hold1", {7'd0, cpu_rst0}, 8'd1);
        tick();
        chk("abort.hold2", {7'd0, cpu_rst0}, 8'd1);
        tick();
        chk0("abort.idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Abort while start pulses are on.
        ext_start = 1'b1;
        ch_enable = 4'h8;
        tick();
        ext_start = 1'b0;
        chk0("abort.start.pre", 1'b0, 4'h8, 1'b1, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk0("abort.start", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("abort.start.idle", {7'd0, cpu_rst0}, 8'd0);

        // Synchronous reset mid-start, with abort also asserted.
        ext_start = 1'b1;
        ch_enable = 4'h6;
        tick();
        ext_start = 1'b0;
        rst = 1'b1;
        abort = 1'b1;
        tick();
        rst = 1'b0;
        abort = 1'b0;
        chk0("rst.mid", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("rst.mid.rc", run_cycles0, 8'd0);
        tick();
        tick();
        chk0("rst.mid.hold", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk0("rst.mid.idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Auto restart on dut1 versus manual restart on dut0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        start_run(4'h1);
        halt_in = 4'h1;
        tick();
        halt_in = 4'h0;
        chk("auto.done1", {7'd0, done1}, 8'd1);
        chk("auto.done0", {7'd0, done0}, 8'd1);
        tick();
        chk("auto.rst1", {7'd0, cpu_rst1}, 8'd1);
        chk("auto.clr1", {7'd0, done1}, 8'd0);
        chk("auto.busy1", {7'd0, busy1}, 8'd0);
        chk("auto.stay0", {7'd0, done0}, 8'd1);
        chk("auto.norst0", {7'd0, cpu_rst0}, 8'd0);
        tick();
        tick();
        chk("auto.hold1", {7'd0, cpu_rst1}, 8'd1);
        tick();
        chk("auto.idle1", {7'd0, cpu_rst1}, 8'd0);
        chk("auto.nostart1", {4'd0, cpu_start1}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of CPU start channels (1..16).
REQ-002 SHALL have parameter RST_HOLD, default 2, giving the core-reset hold length in cycles (>=1).
REQ-003 SHALL have parameter START_W, default 1, giving the start pulse width in cycles (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 50000, giving the run watchdog limit in cycles (>=2).
REQ-005 SHALL have parameter CNT_W, default 20, giving the width of run_cycles; TIMEOUT <= 2^CNT_W-1.
REQ-006 SHALL have parameter AUTO_RESTART, default 0; 1 means restart automatically after completion.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port ext_start, input, 1 bit: run request, level-sampled.
REQ-010 SHALL have port abort, input, 1 bit: forces return to S_RESET.
REQ-011 SHALL have port ch_enable, input, NCH bits: channels to start.
REQ-012 SHALL have port halt_in, input, NCH bits: per-core halted/finished flags.
REQ-013 SHALL have port cpu_rst, output, 1 bit: holds the cores in reset, active high.
REQ-014 SHALL have port cpu_start, output, NCH bits: per-channel start pulse.
REQ-015 SHALL have port busy, output, 1 bit: asserted in S_START and S_RUN.
REQ-016 SHALL have port done, output, 1 bit: all enabled cores halted.
REQ-017 SHALL have port timeout, output, 1 bit: watchdog expired.
REQ-018 SHALL have port run_cycles, output, CNT_W bits: number of S_RUN cycles elapsed.
REQ-019 SHALL register all outputs, with no combinational input-to-output path.

Function
REQ-020 SHALL implement the states S_RESET, S_IDLE, S_START, S_RUN and S_DONE.
REQ-021 SHALL, in S_RESET, hold cpu_rst=1 for exactly RST_HOLD cycles, then enter S_IDLE.
REQ-022 SHALL, in S_IDLE, hold cpu_rst=0 and, when ext_start=1 and ch_enable!=0, latch ch_enable into an internal mask and enter S_START.
REQ-023 SHALL ignore ext_start in S_IDLE while ch_enable==0.
REQ-024 SHALL drive cpu_start=mask for exactly START_W cycles in S_START, starting the cycle after the accepted ext_start, and 0 at all other times.
REQ-025 SHALL enter S_RUN after START_W cycles of S_START, with run_cycles cleared to 0 on entry.
REQ-026 SHALL increment run_cycles by 1 in each S_RUN cycle and never wrap.
REQ-027 SHALL, in S_RUN, enter S_DONE with done=1 when (halt_in & mask)==mask.
REQ-028 SHALL, in S_RUN, enter S_DONE with timeout=1 when run_cycles==TIMEOUT-1.
REQ-029 SHALL give done priority when the done and timeout conditions are true in the same cycle: done=1, timeout=0.
REQ-030 SHALL not sample halt_in in S_START.
REQ-031 SHALL, in S_DONE, hold done, timeout and run_cycles stable and drive busy=0.
REQ-032 SHALL, in S_DONE, enter S_RESET the next cycle when AUTO_RESTART=1, or on ext_start=1 when AUTO_RESTART=0.
REQ-033 SHALL clear done and timeout on entering S_RESET.
REQ-034 SHALL ignore ext_start in S_RESET, S_START and S_RUN.
REQ-035 SHALL, when abort=1 in any state, enter S_RESET next cycle with cpu_start=0, busy=0, done=0 and timeout=0.
REQ-036 SHALL give abort priority over every other transition.
REQ-037 SHALL hold mask constant from S_START through S_DONE; changes to ch_enable during a run have no effect.

Reset
REQ-038 SHALL, on rst=1 sampled at a clk edge, set state=S_RESET, the hold counter to 0, cpu_rst=1, cpu_start=0, busy=0, done=0, timeout=0, run_cycles=0 and mask=0.
REQ-039 SHALL restart the RST_HOLD count when rst is asserted mid-run, with no pulse on cpu_start.
REQ-040 SHALL give rst priority over abort and all other inputs.

Verification (NCH=4, RST_HOLD=3, START_W=2, TIMEOUT=10)
REQ-041 SHALL cover: rst released -> cpu_rst=1 for exactly 3 cycles, then 0; busy=0.
REQ-042 SHALL cover: ch_enable=4'b0101 with a 1-cycle ext_start in S_IDLE -> cpu_start=4'b0101 for 2 cycles, then busy=1 in S_RUN; halt_in=4'b0101 after 5 run cycles -> done=1, run_cycles=5, busy=0.
REQ-043 SHALL cover: halt_in held at 0 -> timeout=1 with run_cycles=9, done=0.
REQ-044 SHALL cover: halt_in completes on the same cycle that run_cycles=9 -> done=1, timeout=0.
REQ-045 SHALL cover: abort in S_RUN -> S_RESET next cycle, cpu_rst=1 for 3 cycles, flags clear; with AUTO_RESTART=1, after done -> cpu_rst re-pulses without ext_start.
REQ-046 SHALL cover: ext_start with ch_enable=0 -> no cpu_start, state stays S_IDLE; ch_enable changed mid-run -> cpu_start and done evaluation still use the latched mask.
